// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the soft RISC-V core's integer register file.
//   XLEN_DEFAULT : default register data width
//   REG_X0       : architectural index of the hard-wired zero register
//   rf_state_t   : register-file sequencing states (clear engine, normal run)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REG_X0       = 0;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

endpackage : riscv_pkg

// File: rtl/riscv_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_scoreboard
// One pending-write bit per architectural register. The issue stage sets a
// bit when it claims a destination; writeback clears it when the value lands.
//   clk, rstn   : clock, synchronous active-low clear of every busy bit
//   set_en/addr : claim a register (x0 claims are dropped)
//   clr_en/addr : writeback retires a register
//   busy_vec    : full scoreboard, bit i = register i has an outstanding write
// -----------------------------------------------------------------------------
module riscv_scoreboard
   import riscv_pkg::*;
#(
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_addr,
   output logic [NREGS-1:0]  busy_vec
);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_vec <= '0;
      end else begin
         // Bit 0 (x0) is only ever written by the reset branch, so it stays 0.
         for (int i = REG_X0 + 1; i < NREGS; i++) begin
            // Set is tested first: a claim issued in the same cycle as the old
            // producer's writeback belongs to a newer producer and must stick.
            if (set_en && set_addr == AW'(i)) begin
               busy_vec[i] <= 1'b1;
            end else if (clr_en && clr_addr == AW'(i)) begin
               busy_vec[i] <= 1'b0;
            end
         end
      end
   end

endmodule : riscv_scoreboard

// File: rtl/riscv_regfile_sb.sv
// -----------------------------------------------------------------------------
// riscv_regfile_sb
// Integer register file with NRP combinational read ports, one write port,
// optional write-to-read bypass and a pending-write scoreboard for RAW hazard
// detection. After reset a clear engine zeroes one register per cycle; the
// file reports ready only once every register holds 0.
//   clk, rstn          : clock, synchronous active-low reset
//   ready              : clear done; reads/writes/claims valid only while high
//   rs_addr / rs_data  : packed read addresses / read data, port i at slice i
//   rs_busy            : per-port outstanding-write flag for the addressed reg
//   wen, rd, wdata     : writeback port (writes to x0 are discarded)
//   claim_en, claim_rd : issue-stage claim of a destination register
//   busy_vec           : full scoreboard
// -----------------------------------------------------------------------------
module riscv_regfile_sb
   import riscv_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEFAULT,
   parameter  int NREGS  = 32,
   parameter  int NRP    = 2,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic                 ready,
   input  logic [NRP*AW-1:0]    rs_addr,
   output logic [NRP*XLEN-1:0]  rs_data,
   output logic [NRP-1:0]       rs_busy,
   input  logic                 wen,
   input  logic [AW-1:0]        rd,
   input  logic [XLEN-1:0]      wdata,
   input  logic                 claim_en,
   input  logic [AW-1:0]        claim_rd,
   output logic [NREGS-1:0]     busy_vec
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
   localparam logic [AW-1:0] X0_ADDR  = AW'(REG_X0);

   rf_state_t        state, state_d;
   logic [AW-1:0]    clr_idx;
   logic [XLEN-1:0]  regs [NREGS];
   logic [AW-1:0]    port_addr [NRP];
   logic             run;
   logic             wr_ok;

   assign run   = (state == RF_RUN);
   assign ready = run;
   assign wr_ok = run && wen && (rd != X0_ADDR);

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else begin
         state <= state_d;
         if (state == RF_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
         end
      end
   end

   // NOTE: every combinational output is given a default before any branch,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state;
      case (state)
         // Only the explicit terminal compare leaves CLEAR; the wrap of
         // clr_idx back to 0 happens in the same edge and is harmless.
         RF_CLEAR: if (clr_idx == LAST_IDX) state_d = RF_RUN;
         RF_RUN:   state_d = RF_RUN;
         default:  state_d = RF_CLEAR;
      endcase
   end

   // ---------------- storage ----------------
   // NOTE: the array has no reset term; it is zeroed by the clear engine one
   // entry per cycle, which keeps it mappable to plain RAM/flops without reset.
   always_ff @(posedge clk) begin
      if (rstn) begin
         if (state == RF_CLEAR) begin
            regs[clr_idx] <= '0;
         end else if (wr_ok) begin
            regs[rd] <= wdata;
         end
      end
   end

   // ---------------- scoreboard ----------------
   riscv_scoreboard #(
      .NREGS    (NREGS)
   ) u_scoreboard (
      .clk      (clk),
      .rstn     (rstn),
      .set_en   (run && claim_en),
      .set_addr (claim_rd),
      .clr_en   (run && wen),
      .clr_addr (rd),
      .busy_vec (busy_vec)
   );

   // ---------------- read ports ----------------
   for (genvar p = 0; p < NRP; p++) begin : g_port_addr
      assign port_addr[p] = rs_addr[p*AW +: AW];
   end

   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      if (run) begin
         for (int i = 0; i < NRP; i++) begin
            if (port_addr[i] == X0_ADDR) begin
               rs_data[i*XLEN +: XLEN] = '0;
               rs_busy[i]              = 1'b0;
            end else if (BYPASS && wen && rd == port_addr[i]) begin
               // Forwarded data is already the producer's result, so the
               // consumer need not stall on the still-set busy bit.
               rs_data[i*XLEN +: XLEN] = wdata;
               rs_busy[i]              = 1'b0;
            end else begin
               rs_data[i*XLEN +: XLEN] = regs[port_addr[i]];
               rs_busy[i]              = busy_vec[port_addr[i]];
            end
         end
      end
   end

endmodule : riscv_regfile_sb

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
- Parametrised integer register file for the soft RISC-V core.
- Configurable width, register count and number of read ports.
- Includes an optional write-to-read bypass and a per-register pending-write scoreboard, so the pipeline can detect RAW hazards.
- On reset, a sequential clear engine zeroes every register before the file reports ready. It sits between decode/issue (reads, claims) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRP, 2, number of independent read ports.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wdata; 0 = it returns the stored value.
- AW, $clog2(NREGS), register address width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, synchronous, active-low.
- ready  out  1  high once the clear sequence is done; reads, writes and claims are valid only while high.
- rs_addr  in  NRP*AW  packed read addresses; port i is at [i*AW +: AW].
- rs_data  out  NRP*XLEN  packed read data; port i is at [i*XLEN +: XLEN].
- rs_busy  out  NRP  port i is high when its register has an outstanding claimed write.
- wen  in  1  writeback enable.
- rd  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- claim_en  in  1  issue stage marks a register as pending.
- claim_rd  in  AW  register being claimed.
- busy_vec  out  NREGS  full scoreboard, for debug and the issue stage.

Behaviour:
- States: CLEAR, RUN.
- Reset: rstn sampled low at a clock edge → next state CLEAR.
  - clr_idx <= 0, busy_vec <= 0, ready <= 0.
  - This applies in any state, including mid-CLEAR, where the clear restarts from index 0.
- CLEAR:
  - Each cycle writes 0 to registers[clr_idx] and increments clr_idx.
  - When clr_idx == NREGS-1, that write happens and the next state is RUN.
  - The clear takes exactly NREGS cycles after rstn rises; ready goes high the cycle after the last clear write.
  - wen and claim_en are ignored.
  - rs_data = 0 and rs_busy = 0.
- RUN, reads:
  - Reads are combinational (zero latency).
  - rs_data[i] = 0 if rs_addr[i] == 0.
  - Otherwise, if BYPASS && wen && rd == rs_addr[i], rs_data[i] = wdata.
  - Otherwise rs_data[i] = registers[rs_addr[i]].
- RUN, writes: on a clock edge with wen && rd != 0, registers[rd] <= wdata. Writes to x0 are discarded.
- Scoreboard, edge updates:
  - wen && rd != 0 clears busy[rd].
  - claim_en && claim_rd != 0 sets busy[claim_rd].
  - Claim and write to the same register in the same cycle: the claim wins and busy stays 1 (a new producer has issued).
  - busy[0] is constantly 0.
- rs_busy[i] = busy[rs_addr[i]], except that it is forced 0 when BYPASS && wen && rd == rs_addr[i] && rd != 0 (data forwarded this cycle).
  - With BYPASS = 0, rs_busy stays high through the write cycle and clears the next cycle.
- Ports read independently; several ports may read the same address.
- No arithmetic besides clr_idx increment.
  - clr_idx is AW bits wide; it must not wrap into RUN except via the NREGS-1 terminal compare.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN default and REG_X0 = 0 constant.
  - The rf_state_t enum {RF_CLEAR, RF_RUN}.
- One sub-module, riscv_scoreboard, holds the NREGS busy bits.
  - Inputs: set/clear controls and the sync clear.
  - Outputs: busy_vec.
  - Instantiated once; the read-port busy mux stays in the top level.

Test Plan:
- Defaults; release rstn after random values were preloaded → ready stays low for 32 cycles, rises on cycle 33; every register then reads 0.
- RUN: write rd=5 wdata=0xDEADBEEF, read port0 addr 5 in the same cycle → rs_data0 = 0xDEADBEEF with BYPASS=1; with BYPASS=0 the old value that cycle, 0xDEADBEEF the next cycle.
- Write rd=0 wdata=0x12345678 → read of addr 0 on both ports returns 0, busy_vec[0] = 0.
- Scoreboard sequence:
  - Claim 7 → busy_vec[7] = 1, and rs_busy1 = 1 while rs_addr1 = 7.
  - Write 7 → busy_vec[7] = 0 the next cycle.
  - Claim 7 and write 7 in the same cycle → busy_vec[7] stays 1.
- Assert rstn low at CLEAR cycle 10 for one cycle → clear restarts at index 0; ready rises 32 cycles after release; busy_vec = 0.
- NREGS=16, NRP=3, XLEN=64: write 0xFFFF_0000_FFFF_0000 to rd=15, read it on ports 0–2 → all three return the value; clear length is 16 cycles.
